// File: rtl/riscv_types_pkg.sv
// Shared RISC-V front-end types: address width and fetch-stage FSM/metadata.
// Pure type definitions, no logic and no latency.
// No flow control.
package riscv_types_pkg;

    localparam int ADDR_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    // Per-fetch record handed to decode for later resolution and predictor update.
    typedef struct packed {
        addr_t pc;
        logic  pred_taken;
        addr_t pred_target;
        logic  btb_hit;
        logic  epoch;
    } fetch_meta_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Fetch next-PC generator: drives predictor lookup, issues imem req/gnt fetches, applies redirects.
// Latency: next PC chosen in the same cycle as the grant; fetch metadata valid one cycle after grant.
// Backpressure: stall_i blocks new requests only; an ungranted request is held until granted.
module fetch_pc_gen
    import riscv_types_pkg::*;
#(
    parameter addr_t RESET_VECTOR = 32'h0000_0000
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    output addr_t pc_o,
    input  logic  predict_taken_i,
    input  addr_t predict_target_i,
    input  logic  btb_hit_i,
    output logic  imem_req_o,
    output addr_t imem_addr_o,
    input  logic  imem_gnt_i,
    input  logic  stall_i,
    input  logic  redirect_i,
    input  addr_t redirect_pc_i,
    output logic  fetch_valid_o,
    output addr_t fetch_pc_o,
    output logic  fetch_pred_taken_o,
    output addr_t fetch_pred_target_o,
    output logic  fetch_btb_hit_o,
    output logic  fetch_epoch_o
);

    fetch_state_e r_state;
    addr_t        r_pc;
    logic         r_pending;
    addr_t        r_pending_pc;
    logic         r_fetch_valid;
    // r_meta.epoch doubles as the live epoch register: it toggles on every
    // accepted redirect, and every emitted fetch was granted in the current epoch.
    fetch_meta_t  r_meta;

    fetch_state_e w_state_nxt;
    addr_t        w_pc_nxt;
    logic         w_pending_nxt;
    addr_t        w_pending_pc_nxt;
    logic         w_epoch_nxt;
    logic         w_req;
    logic         w_fire;
    addr_t        w_redir_pc;
    addr_t        w_seq_pc;
    addr_t        w_pred_pc;

    assign w_redir_pc = redirect_pc_i & ~addr_t'(3);
    assign w_seq_pc   = r_pc + addr_t'(4);
    assign w_pred_pc  = predict_taken_i ? predict_target_i : w_seq_pc;

    // Next-state, next-PC, redirect bookkeeping and request generation.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_pending_nxt    = r_pending;
        w_pending_pc_nxt = r_pending_pc;
        w_epoch_nxt      = r_meta.epoch ^ redirect_i;
        w_req            = 1'b0;
        w_fire           = 1'b0;
        case (r_state)
            BOOT: begin
                w_state_nxt = RUN;
                if (redirect_i) begin
                    w_pc_nxt = w_redir_pc;
                end
            end
            RUN: begin
                w_req = !stall_i;
                if (redirect_i) begin
                    if (w_req && !imem_gnt_i) begin
                        // The request is already on the bus and may not be
                        // withdrawn; park the target until it is granted.
                        w_state_nxt      = WAIT;
                        w_pending_nxt    = 1'b1;
                        w_pending_pc_nxt = w_redir_pc;
                    end else begin
                        // Stalled or granted-and-killed: jump straight away.
                        w_pc_nxt = w_redir_pc;
                    end
                end else if (w_req && imem_gnt_i) begin
                    w_fire   = 1'b1;
                    w_pc_nxt = w_pred_pc;
                end else if (w_req) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                w_req = 1'b1;
                if (imem_gnt_i) begin
                    w_state_nxt   = RUN;
                    w_pending_nxt = 1'b0;
                    if (redirect_i) begin
                        w_pc_nxt = w_redir_pc;
                    end else if (r_pending) begin
                        w_pc_nxt = r_pending_pc;
                    end else begin
                        w_fire   = 1'b1;
                        w_pc_nxt = w_pred_pc;
                    end
                end else if (redirect_i) begin
                    w_pending_nxt    = 1'b1;
                    w_pending_pc_nxt = w_redir_pc;
                end
            end
            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // State, PC, pending redirect and per-fetch metadata registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_pending     <= 1'b0;
            r_pending_pc  <= '0;
            r_fetch_valid <= 1'b0;
            r_meta        <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pending     <= w_pending_nxt;
            r_pending_pc  <= w_pending_pc_nxt;
            r_fetch_valid <= w_fire;
            r_meta.epoch  <= w_epoch_nxt;
            if (w_fire) begin
                r_meta.pc          <= r_pc;
                r_meta.pred_taken  <= predict_taken_i;
                r_meta.pred_target <= w_pred_pc;
                r_meta.btb_hit     <= btb_hit_i;
            end
        end
    end

    assign pc_o                = r_pc;
    assign imem_addr_o         = r_pc;
    assign imem_req_o          = w_req;
    assign fetch_valid_o       = r_fetch_valid;
    assign fetch_pc_o          = r_meta.pc;
    assign fetch_pred_taken_o  = r_meta.pred_taken;
    assign fetch_pred_target_o = r_meta.pred_target;
    assign fetch_btb_hit_o     = r_meta.btb_hit;
    assign fetch_epoch_o       = r_meta.epoch;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized run against a transaction-level model.
// Latency: inputs driven 1 time unit after posedge, outputs sampled 1 unit later.
// Backpressure: stall_i and imem_gnt_i driven directly by the scenarios.
module tb_fetch_pc_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] pc_o;
    logic        predict_taken_i;
    logic [31:0] predict_target_i;
    logic        btb_hit_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_pc_o;
    logic        fetch_pred_taken_o;
    logic [31:0] fetch_pred_target_o;
    logic        fetch_btb_hit_o;
    logic        fetch_epoch_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] RV = 32'h0000_0100;

    fetch_pc_gen #(.RESET_VECTOR(RV)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .pc_o                (pc_o),
        .predict_taken_i     (predict_taken_i),
        .predict_target_i    (predict_target_i),
        .btb_hit_i           (btb_hit_i),
        .imem_req_o          (imem_req_o),
        .imem_addr_o         (imem_addr_o),
        .imem_gnt_i          (imem_gnt_i),
        .stall_i             (stall_i),
        .redirect_i          (redirect_i),
        .redirect_pc_i       (redirect_pc_i),
        .fetch_valid_o       (fetch_valid_o),
        .fetch_pc_o          (fetch_pc_o),
        .fetch_pred_taken_o  (fetch_pred_taken_o),
        .fetch_pred_target_o (fetch_pred_target_o),
        .fetch_btb_hit_o     (fetch_btb_hit_o),
        .fetch_epoch_o       (fetch_epoch_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; stall_i = 1'b0; imem_gnt_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        predict_taken_i = 1'b0; predict_target_i = '0; btb_hit_i = 1'b0;
        cyc(); cyc(); #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", imem_req_o); end
        total++; if (pc_o !== RV) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc_o, RV); end
        total++; if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL rst_vld got=%0b exp=0", fetch_valid_o); end
        total++; if (fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL rst_epoch got=%0b exp=0", fetch_epoch_o); end
        total++; if (fetch_pc_o !== 32'h0) begin bad++; $display("FAIL rst_fpc got=%h exp=0", fetch_pc_o); end
    endtask

    task automatic test_boot_seq();
        cyc(); rst_ni = 1'b1; #1;
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL boot_req got=%0b exp=0", imem_req_o); end
        cyc(); #1;
        total++; if (imem_req_o !== 1'b1 || imem_addr_o !== RV) begin bad++; $display("FAIL boot_first req=%0b addr=%h exp req=1 addr=%h", imem_req_o, imem_addr_o, RV); end
        total++; if (fetch_valid_o !== 1'b0) begin bad++; $display("FAIL boot_novld got=%0b exp=0", fetch_valid_o); end
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            total++; if (imem_addr_o !== RV + 32'd4 * (i + 1)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imem_addr_o, RV + 32'd4 * (i + 1)); end
            total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== RV + 32'd4 * i) begin bad++; $display("FAIL seq_fetch%0d vld=%0b pc=%h exp vld=1 pc=%h", i, fetch_valid_o, fetch_pc_o, RV + 32'd4 * i); end
            total++; if (fetch_pred_target_o !== RV + 32'd4 * (i + 1) || fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL seq_meta%0d tgt=%h ep=%0b exp tgt=%h ep=0", i, fetch_pred_target_o, fetch_epoch_o, RV + 32'd4 * (i + 1)); end
        end
    endtask

    task automatic test_predict_taken();
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        cyc(); redirect_i = 1'b0; predict_taken_i = 1'b1; predict_target_i = 32'h80; btb_hit_i = 1'b1; #1;
        total++; if (imem_addr_o !== 32'h200 || fetch_valid_o !== 1'b0) begin bad++; $display("FAIL pt_setup addr=%h vld=%0b exp addr=200 vld=0", imem_addr_o, fetch_valid_o); end
        total++; if (fetch_epoch_o !== 1'b1) begin bad++; $display("FAIL pt_epoch got=%0b exp=1", fetch_epoch_o); end
        cyc(); predict_taken_i = 1'b0; btb_hit_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h80) begin bad++; $display("FAIL pt_addr got=%h exp=80", imem_addr_o); end
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h200) begin bad++; $display("FAIL pt_fetch vld=%0b pc=%h exp vld=1 pc=200", fetch_valid_o, fetch_pc_o); end
        total++; if (fetch_pred_taken_o !== 1'b1 || fetch_pred_target_o !== 32'h80 || fetch_btb_hit_o !== 1'b1) begin bad++; $display("FAIL pt_meta tk=%0b tgt=%h btb=%0b exp 1/80/1", fetch_pred_taken_o, fetch_pred_target_o, fetch_btb_hit_o); end
    endtask

    task automatic test_wait_stall();
        redirect_i = 1'b1; redirect_pc_i = 32'h300;
        cyc(); redirect_i = 1'b0; imem_gnt_i = 1'b0; stall_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h300 || imem_req_o !== 1'b1 || fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL ws_setup addr=%h req=%0b ep=%0b exp 300/1/0", imem_addr_o, imem_req_o, fetch_epoch_o); end
        for (int i = 0; i < 2; i++) begin
            cyc(); stall_i = (i == 0); #1;
            total++; if (imem_addr_o !== 32'h300 || imem_req_o !== 1'b1 || fetch_valid_o !== 1'b0) begin bad++; $display("FAIL ws_hold%0d addr=%h req=%0b vld=%0b exp 300/1/0", i, imem_addr_o, imem_req_o, fetch_valid_o); end
        end
        imem_gnt_i = 1'b1; stall_i = 1'b1; #1;
        total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL ws_req_stalled got=%0b exp=1", imem_req_o); end
        cyc(); #1;
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h300 || imem_addr_o !== 32'h304) begin bad++; $display("FAIL ws_grant vld=%0b pc=%h addr=%h exp 1/300/304", fetch_valid_o, fetch_pc_o, imem_addr_o); end
        total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL ws_run_stall got=%0b exp=0", imem_req_o); end
        cyc(); #1;
        total++; if (fetch_valid_o !== 1'b0 || imem_addr_o !== 32'h304) begin bad++; $display("FAIL ws_single vld=%0b addr=%h exp 0/304", fetch_valid_o, imem_addr_o); end
    endtask

    task automatic test_redirect_wait();
        redirect_i = 1'b1; redirect_pc_i = 32'h500;
        cyc(); redirect_i = 1'b0; stall_i = 1'b0; imem_gnt_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h500 || fetch_epoch_o !== 1'b1) begin bad++; $display("FAIL rw_stall_redir addr=%h ep=%0b exp 500/1", imem_addr_o, fetch_epoch_o); end
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h403; #1;
        cyc(); redirect_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h500 || imem_req_o !== 1'b1 || fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL rw_pend addr=%h req=%0b ep=%0b exp 500/1/0", imem_addr_o, imem_req_o, fetch_epoch_o); end
        cyc(); imem_gnt_i = 1'b1; #1;
        total++; if (imem_addr_o !== 32'h500 || fetch_valid_o !== 1'b0) begin bad++; $display("FAIL rw_hold addr=%h vld=%0b exp 500/0", imem_addr_o, fetch_valid_o); end
        cyc(); #1;
        total++; if (fetch_valid_o !== 1'b0 || imem_addr_o !== 32'h400 || imem_req_o !== 1'b1) begin bad++; $display("FAIL rw_kill vld=%0b addr=%h req=%0b exp 0/400/1", fetch_valid_o, imem_addr_o, imem_req_o); end
        total++; if (fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL rw_epoch got=%0b exp=0", fetch_epoch_o); end
        cyc(); #1;
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h400 || imem_addr_o !== 32'h404) begin bad++; $display("FAIL rw_resume vld=%0b pc=%h addr=%h exp 1/400/404", fetch_valid_o, fetch_pc_o, imem_addr_o); end
    endtask

    task automatic test_redirect_grant_run();
        redirect_i = 1'b1; redirect_pc_i = 32'h1000;
        cyc(); redirect_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'h1000 || fetch_valid_o !== 1'b0 || fetch_epoch_o !== 1'b1) begin bad++; $display("FAIL rg_kill addr=%h vld=%0b ep=%0b exp 1000/0/1", imem_addr_o, fetch_valid_o, fetch_epoch_o); end
        cyc(); #1;
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== 32'h1000 || imem_addr_o !== 32'h1004) begin bad++; $display("FAIL rg_next vld=%0b pc=%h addr=%h exp 1/1000/1004", fetch_valid_o, fetch_pc_o, imem_addr_o); end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
        cyc(); redirect_i = 1'b0; #1;
        total++; if (imem_addr_o !== 32'hFFFF_FFFC || fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL wrap_mask addr=%h ep=%0b exp fffffffc/0", imem_addr_o, fetch_epoch_o); end
        cyc(); #1;
        total++; if (imem_addr_o !== 32'h0 || fetch_pc_o !== 32'hFFFF_FFFC || fetch_pred_target_o !== 32'h0) begin bad++; $display("FAIL wrap_adv addr=%h fpc=%h tgt=%h exp 0/fffffffc/0", imem_addr_o, fetch_pc_o, fetch_pred_target_o); end
    endtask

    task automatic test_reset_wait();
        imem_gnt_i = 1'b0;
        cyc(); redirect_i = 1'b1; redirect_pc_i = 32'h2000;
        cyc(); redirect_i = 1'b0; rst_ni = 1'b0; #1;
        total++; if (imem_req_o !== 1'b1 || fetch_epoch_o !== 1'b1) begin bad++; $display("FAIL rwt_pre req=%0b ep=%0b exp 1/1", imem_req_o, fetch_epoch_o); end
        cyc(); #1;
        total++; if (imem_req_o !== 1'b0 || pc_o !== RV || fetch_valid_o !== 1'b0 || fetch_epoch_o !== 1'b0) begin bad++; $display("FAIL rwt_rst req=%0b pc=%h vld=%0b ep=%0b exp 0/%h/0/0", imem_req_o, pc_o, fetch_valid_o, fetch_epoch_o, RV); end
        rst_ni = 1'b1; imem_gnt_i = 1'b1;
        cyc(); cyc(); #1;
        total++; if (fetch_valid_o !== 1'b1 || fetch_pc_o !== RV || imem_addr_o !== RV + 32'd4) begin bad++; $display("FAIL rwt_nopend vld=%0b pc=%h addr=%h exp 1/%h/%h", fetch_valid_o, fetch_pc_o, imem_addr_o, RV, RV + 32'd4); end
    endtask

    // Transaction-level reference: a fetch is either free to issue or
    // outstanding (issued, not yet granted); a redirect against an
    // outstanding fetch is remembered and applied when that fetch is granted.
    task automatic test_random();
        logic [31:0] m_pc, m_pend_pc, m_fpc, m_ftgt, rpc, nxt;
        bit m_boot, m_out, m_pend, m_epoch, m_vld, m_ftk, m_fbtb;
        bit e_req, grant, kill, do_rst;
        rst_ni = 1'b0; redirect_i = 1'b0;
        cyc(); cyc();
        m_pc = RV; m_pend_pc = '0; m_boot = 1'b1; m_out = 1'b0; m_pend = 1'b0; m_epoch = 1'b0;
        m_vld = 1'b0; m_fpc = '0; m_ftgt = '0; m_ftk = 1'b0; m_fbtb = 1'b0;
        for (int n = 0; n < 600; n++) begin
            do_rst           = ($urandom_range(0, 59) == 0);
            rst_ni           = !do_rst;
            stall_i          = ($urandom_range(0, 3) == 0);
            imem_gnt_i       = ($urandom_range(0, 2) != 0);
            redirect_i       = ($urandom_range(0, 7) == 0);
            redirect_pc_i    = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
            predict_taken_i  = 1'($urandom_range(0, 1));
            predict_target_i = 32'($urandom) & 32'hFFFF_FFFC;
            btb_hit_i        = 1'($urandom_range(0, 1));
            #1;
            e_req = !m_boot && (m_out || !stall_i);
            total++; if (imem_req_o !== e_req) begin bad++; $display("FAIL rnd_req n=%0d got=%0b exp=%0b", n, imem_req_o, e_req); end
            total++; if (imem_addr_o !== m_pc || pc_o !== m_pc) begin bad++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, imem_addr_o, m_pc); end
            total++; if (fetch_valid_o !== m_vld) begin bad++; $display("FAIL rnd_vld n=%0d got=%0b exp=%0b", n, fetch_valid_o, m_vld); end
            total++; if (fetch_epoch_o !== m_epoch) begin bad++; $display("FAIL rnd_epoch n=%0d got=%0b exp=%0b", n, fetch_epoch_o, m_epoch); end
            if (m_vld) begin
                total++; if (fetch_pc_o !== m_fpc || fetch_pred_target_o !== m_ftgt) begin bad++; $display("FAIL rnd_meta n=%0d pc=%h tgt=%h exp %h/%h", n, fetch_pc_o, fetch_pred_target_o, m_fpc, m_ftgt); end
                total++; if (fetch_pred_taken_o !== m_ftk || fetch_btb_hit_o !== m_fbtb) begin bad++; $display("FAIL rnd_flags n=%0d tk=%0b btb=%0b exp %0b/%0b", n, fetch_pred_taken_o, fetch_btb_hit_o, m_ftk, m_fbtb); end
            end
            if (do_rst) begin
                m_pc = RV; m_boot = 1'b1; m_out = 1'b0; m_pend = 1'b0; m_epoch = 1'b0; m_vld = 1'b0;
            end else begin
                rpc   = redirect_pc_i & 32'hFFFF_FFFC;
                grant = e_req && imem_gnt_i;
                kill  = redirect_i || m_pend;
                nxt   = predict_taken_i ? predict_target_i : m_pc + 32'd4;
                m_vld = grant && !kill;
                if (redirect_i) m_epoch = !m_epoch;
                if (m_boot) begin
                    m_boot = 1'b0;
                    if (redirect_i) m_pc = rpc;
                end else if (grant) begin
                    if (!kill) begin
                        m_fpc = m_pc; m_ftk = predict_taken_i; m_ftgt = nxt; m_fbtb = btb_hit_i;
                        m_pc = nxt;
                    end else begin
                        m_pc = redirect_i ? rpc : m_pend_pc;
                    end
                    m_out = 1'b0; m_pend = 1'b0;
                end else if (e_req) begin
                    m_out = 1'b1;
                    if (redirect_i) begin m_pend = 1'b1; m_pend_pc = rpc; end
                end else if (redirect_i) begin
                    m_pc = rpc;
                end
            end
            cyc();
        end
        rst_ni = 1'b1; redirect_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_boot_seq();
        test_predict_taken();
        test_wait_stall();
        test_redirect_wait();
        test_redirect_grant_run();
        test_wrap();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator. It sits directly upstream of the branch predictor: it drives the predictor lookup PC and consumes the same-cycle prediction to pick the next fetch address. It also issues req/gnt fetch requests to instruction memory, applies execute-stage redirects, and passes per-fetch prediction metadata to decode for later resolution and predictor update.

## Interface
- RESET_VECTOR, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk_i  in  1  system clock
- rst_ni  in  1  synchronous active-low reset, sampled on posedge clk_i
- pc_o  out  addr_t  current fetch PC; drives predictor pc_i
- predict_taken_i  in  1  predictor taken decision for pc_o, same cycle
- predict_target_i  in  addr_t  predictor target for pc_o
- btb_hit_i  in  1  predictor BTB hit for pc_o
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  addr_t  fetch address (= pc_o)
- imem_gnt_i  in  1  request accepted this cycle
- stall_i  in  1  decode backpressure; blocks new requests
- redirect_i  in  1  execute redirect (mispredict, jump, trap)
- redirect_pc_i  in  addr_t  redirect target; bits [1:0] forced to 0 internally
- fetch_valid_o  out  1  one-cycle pulse per granted, non-killed fetch
- fetch_pc_o  out  addr_t  PC of that fetch
- fetch_pred_taken_o  out  1  prediction used for that fetch
- fetch_pred_target_o  out  addr_t  next PC chosen for that fetch
- fetch_btb_hit_o  out  1  BTB hit flag for that fetch
- fetch_epoch_o  out  1  epoch tag; toggles on every accepted redirect

## Operation
- Reset values: pc_o=RESET_VECTOR, imem_req_o=0, fetch_valid_o=0, all fetch_* data=0, fetch_epoch_o=0, state BOOT, redirect_pending=0.
- FSM states: BOOT, RUN, WAIT.
- BOOT:
  - imem_req_o=0.
  - Next cycle goes to RUN.
  - A redirect in BOOT loads pc and toggles epoch.
- RUN:
  - imem_req_o = !stall_i.
  - If requesting and imem_gnt_i: advance pc; stay in RUN.
  - If requesting and !imem_gnt_i: go to WAIT.
- WAIT:
  - imem_req_o=1 regardless of stall_i.
  - pc_o/imem_addr_o held stable.
  - On imem_gnt_i: advance pc; go to RUN.
- Advance rule: next pc = predict_taken_i ? predict_target_i : pc_o + 4. The sum is 32-bit and wraps at 2^32.
- Metadata on grant: fetch_* are registered from the current pc_o and prediction inputs. fetch_valid_o is set next cycle unless the fetch is killed.
- Redirect in RUN:
  - pc <= redirect_pc_i & ~3; epoch toggles.
  - A grant in the same cycle is killed: no fetch_valid_o, pc not advanced.
  - Redirect has priority over stall_i.
- Redirect in WAIT:
  - The outstanding request is not withdrawn.
  - Target is latched into redirect_pending/pending_pc and epoch toggles immediately.
  - On grant, that fetch is killed and pc <= pending_pc; pending clears.
  - A later redirect while pending overwrites pending_pc and toggles epoch again.
  - Redirect in the same cycle as the grant in WAIT: that redirect wins over any pending target.
- Prediction inputs are ignored in any cycle with redirect_i or a pending redirect being applied.
- Synchronous reset mid-request drops the request immediately; imem must tolerate withdrawal on reset only.

## Timing
- One-cycle next-PC loop: pc register → predictor (combinational) → mux → pc register.
- fetch_valid_o and fetch_* appear the cycle after imem_gnt_i.
- Redirect to first request at the new target: 0 cycles after the redirect edge in RUN (pc_o updates next cycle, req in that cycle). In WAIT, first request is in the cycle after the grant.
- First request after reset deassertion: 2nd rising edge (BOOT occupies one cycle).
- Throughput: one fetch per cycle with gnt held high and no stall.

## Structure
- riscv_types_pkg additions:
  - fetch_state_e (BOOT, RUN, WAIT).
  - fetch_meta_t packed struct {pc, pred_taken, pred_target, btb_hit, epoch}.
  - Uses existing addr_t/ADDR_WIDTH.
- Single flat module, no sub-module; FSM, pc register, pending register and metadata register live in fetch_pc_gen.

## Test plan
- Reset, gnt=1, predict_taken=0, RESET_VECTOR=0x100 → req from 2nd cycle at 0x100, 0x104, 0x108; fetch_valid_o pulses each cycle after; epoch=0.
- At pc=0x200, predict_taken=1, target=0x80 with gnt → next imem_addr_o=0x80; fetch_pred_target_o=0x80, fetch_btb_hit_o=1.
- gnt=0 for 3 cycles with stall_i toggling → addr held at 0x300 and req stays high; single fetch_valid_o after the grant.
- Redirect to 0x403 in WAIT at 0x500, grant 2 cycles later → no fetch_valid_o for 0x500; next request at 0x400; epoch toggled once.
- Redirect to 0x1000 plus gnt in the same RUN cycle → fetch killed; next address 0x1000; pc not advanced to pc+4.
- rst_ni low during WAIT → next cycle req=0, pc=RESET_VECTOR, fetch_valid_o=0, pending cleared.
